// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, 12 MHz timing defaults, command bytes.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE,
    DONE
  } ps2_state_t;

  // 100 us inhibit and 15 ms per-edge watchdog at 12 MHz
  localparam int PS2_INHIBIT_CYCLES = 1200;
  localparam int PS2_TIMEOUT_CYCLES = 180000;

  localparam logic [7:0] CMD_RESET        = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS     = 8'hED;
  localparam logic [7:0] CMD_MOUSE_ENABLE = 8'hF4;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [7:0] din;
  logic       send;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       error;
  logic       rx_inhibit;

  modport master (
    output din, send,
    input  busy, done, ack_ok, error, rx_inhibit
  );

  modport slave (
    input  din, send,
    output busy, done, ack_ok, error, rx_inhibit
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer and falling-edge detector for the PS/2 clock and data pads.
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pad,
  input  logic data_pad,
  output logic clk_level,
  output logic data_level,
  output logic clk_fall,
  output logic data_fall
);

  logic [1:0] pad_w;
  logic [1:0] level_w;
  logic [1:0] fall_w;

  assign pad_w = {data_pad, clk_pad};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;

      // Reset to the idle (released, pulled-up) level so no false edge follows reset
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
          prev_reg <= 1'b1;
        end else begin
          meta_reg <= pad_w[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end

      assign level_w[gi] = sync_reg;
      assign fall_w[gi]  = prev_reg & ~sync_reg;
    end
  endgenerate

  assign clk_level  = level_w[0];
  assign data_level = level_w[1];
  assign clk_fall   = fall_w[0];
  assign data_fall  = fall_w[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-collector output enables.
// Build option: PS2TX_TIMEOUT_EN adds a per-edge watchdog for an absent device.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ps2clk_in,
  input  logic               ps2data_in,
  output logic               ps2clk_oe,
  output logic               ps2data_oe,
  ps2_host_tx_if.slave       bus
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  logic clk_s;
  logic data_s;
  logic clk_fall;
  logic data_fall_unused;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_pad    (ps2clk_in),
    .data_pad   (ps2data_in),
    .clk_level  (clk_s),
    .data_level (data_s),
    .clk_fall   (clk_fall),
    .data_fall  (data_fall_unused)
  );

  ps2_state_t       state_reg, state_next;
  logic [7:0]       din_reg, din_next;
  logic             parity_reg, parity_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic             clk_oe_reg, clk_oe_next;
  logic             data_oe_reg, data_oe_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;
  logic             ack_ok_reg, ack_ok_next;
  logic             error_reg, error_next;

`ifdef PS2TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
`else
  // Timeout length is still accepted so both builds share one parameter list
  localparam int TIMEOUT_CYCLES_UNUSED = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      din_reg     <= '0;
      parity_reg  <= 1'b0;
      bit_cnt_reg <= '0;
      inh_cnt_reg <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      ack_ok_reg  <= 1'b0;
      error_reg   <= 1'b0;
`ifdef PS2TX_TIMEOUT_EN
      wd_cnt_reg  <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      din_reg     <= din_next;
      parity_reg  <= parity_next;
      bit_cnt_reg <= bit_cnt_next;
      inh_cnt_reg <= inh_cnt_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      ack_ok_reg  <= ack_ok_next;
      error_reg   <= error_next;
`ifdef PS2TX_TIMEOUT_EN
      wd_cnt_reg  <= wd_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    din_next     = din_reg;
    parity_next  = parity_reg;
    bit_cnt_next = bit_cnt_reg;
    inh_cnt_next = inh_cnt_reg;
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    done_next    = 1'b0;
    ack_ok_next  = ack_ok_reg;
    error_next   = error_reg;
`ifdef PS2TX_TIMEOUT_EN
    wd_cnt_next  = '0;
`endif

    unique case (state_reg)
      IDLE: begin
        if (bus.send) begin
          din_next     = bus.din;
          parity_next  = odd_parity(bus.din);
          inh_cnt_next = '0;
          ack_ok_next  = 1'b0;
          error_next   = 1'b0;
          clk_oe_next  = 1'b1;
          state_next   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_reg == INH_LAST) begin
          data_oe_next = 1'b1;
          state_next   = REQ;
        end else begin
          inh_cnt_next = inh_cnt_reg + INH_W'(1);
        end
      end
      REQ: begin
        clk_oe_next  = 1'b0;
        bit_cnt_next = '0;
        state_next   = DATA;
      end
      DATA: begin
        // Counter wraps 7->0 on the same fall that moves us to PARITY
        if (clk_fall) begin
          data_oe_next = ~din_reg[bit_cnt_reg];
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (clk_fall) begin
          data_oe_next = ~parity_reg;
          state_next   = STOP;
        end
      end
      STOP: begin
        if (clk_fall) begin
          data_oe_next = 1'b0;
          state_next   = ACK;
        end
      end
      ACK: begin
        if (clk_fall) begin
          ack_ok_next = ~data_s;
          error_next  = data_s;
          state_next  = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

`ifdef PS2TX_TIMEOUT_EN
    if (state_reg inside {DATA, PARITY, STOP, ACK, WAIT_IDLE}) begin
      if (clk_fall) begin
        wd_cnt_next = '0;
      end else if (wd_cnt_reg == WD_LAST) begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        ack_ok_next  = 1'b0;
        error_next   = 1'b1;
        done_next    = 1'b1;
        state_next   = DONE;
      end else begin
        wd_cnt_next = wd_cnt_reg + WD_W'(1);
      end
    end
`endif

    busy_next = (state_next != IDLE) && (state_next != DONE);
  end

  assign ps2clk_oe      = clk_oe_reg;
  assign ps2data_oe     = data_oe_reg;
  assign bus.busy       = busy_reg;
  assign bus.rx_inhibit = busy_reg;
  assign bus.done       = done_reg;
  assign bus.ack_ok     = ack_ok_reg;
  assign bus.error      = error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector device model, vector table, random frames, corner sequences.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int TB_INHIBIT = 1200;
  localparam int TB_TIMEOUT = 6000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2clk_oe, ps2data_oe;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic clk_line, data_line;

  always #5 clk = ~clk;

  assign clk_line  = ~(ps2clk_oe  | dev_clk_low);
  assign data_line = ~(ps2data_oe | dev_data_low);

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES (TB_INHIBIT),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2clk_in  (clk_line),
    .ps2data_in (data_line),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .bus        (bus)
  );

  typedef struct {
    logic [7:0] din;
    bit         dev_ack;
    int         half;
    bit         exp_ack_ok;
    bit         exp_error;
    bit         exp_parity;
  } vec_t;

  int n_vec = 0, n_miss = 0;
  int cyc = 0;
  int done_pulses = 0;
  int done_base = 0;
  int dev_rises = 0;
  int last_fall_cyc = 0;
  bit cap_bits [10];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.done) done_pulses++;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL global_timeout: got cycle %0d, want finish earlier", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: odd parity from a plain bit count
  function automatic bit model_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += (d >> i) & 1;
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic start_frame(input logic [7:0] d);
    int cnt = 0;
    int waited = 0;
    dev_rises = 0;
    done_base = done_pulses;
    @(negedge clk);
    bus.din  = d;
    bus.send = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    bus.din  = 8'h00;
    chk("busy_rise", int'(bus.busy), 1);
    while (!ps2data_oe && waited < TB_INHIBIT + 500) begin
      if (ps2clk_oe) cnt++;
      waited++;
      @(negedge clk);
    end
    chk("inhibit_cycles", cnt, TB_INHIBIT);
    waited = 0;
    while (ps2clk_oe && waited < 10) begin
      waited++;
      @(negedge clk);
    end
    chk("clk_released", int'(ps2clk_oe), 0);
    chk("start_bit", int'(data_line), 0);
  endtask

  // Device: generates npulses clock pulses, samples data on rising edges, ACKs before the 11th fall
  task automatic device_clock(input int half, input bit ack, input int npulses);
    wait_cycles(20);
    for (int i = 0; i < npulses; i++) begin
      dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      wait_cycles(half);
      dev_clk_low = 1'b0;
      if (i < 10) cap_bits[i] = data_line;
      dev_rises++;
      if (i == npulses - 1) break;
      if (i == 9) begin
        wait_cycles(half / 2);
        dev_data_low = ack;
        wait_cycles(half - half / 2);
      end else begin
        wait_cycles(half);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_frame(input logic [7:0] d, input bit e_ack, input bit e_err, input bit e_par);
    logic [7:0] got = '0;
    bit seen;
    int a, e;
    for (int i = 0; i < 8; i++) got[i] = cap_bits[i];
    chk("data_bits", int'(got), int'(d));
    chk("parity_bit", int'(cap_bits[8]), int'(e_par));
    chk("stop_bit", int'(cap_bits[9]), 1);
    wait_done(3000, seen);
    chk("done_seen", int'(seen), 1);
    a = int'(bus.ack_ok);
    e = int'(bus.error);
    if (seen) begin
      chk("ack_ok", a, int'(e_ack));
      chk("error", e, int'(e_err));
    end
    wait_cycles(4);
    chk("oe_released", int'({ps2clk_oe, ps2data_oe}), 0);
    chk("busy_low", int'(bus.busy), 0);
    chk("done_pulse_count", done_pulses - done_base, 1);
    chk("ack_ok_held", int'(bus.ack_ok), int'(e_ack));
    $display("frame din=%02h bits=%02h par=%0d ack_ok=%0d error=%0d", d, got, cap_bits[8], a, e);
  endtask

  vec_t tbl [5];

  initial begin
    bit seen;
    logic [7:0] rd;
    bit rack;
    int rhalf;

    tbl[0] = '{CMD_MOUSE_ENABLE, 1'b1, 480, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{CMD_SET_LEDS,     1'b1,  40, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{CMD_RESET,        1'b1,  40, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h00,            1'b0,  40, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{8'h01,            1'b0,  50, 1'b0, 1'b1, 1'b0};

    bus.din  = 8'h00;
    bus.send = 1'b0;
    rst_n    = 1'b0;
    wait_cycles(5);
    chk("rst_oe", int'({ps2clk_oe, ps2data_oe}), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_flags", int'({bus.ack_ok, bus.error, bus.rx_inhibit}), 0);
    rst_n = 1'b1;
    wait_cycles(5);

    for (int v = 0; v < 5; v++) begin
      start_frame(tbl[v].din);
      device_clock(tbl[v].half, tbl[v].dev_ack, 11);
      finish_frame(tbl[v].din, tbl[v].exp_ack_ok, tbl[v].exp_error, tbl[v].exp_parity);
    end

    for (int v = 0; v < 6; v++) begin
      rd    = 8'($urandom_range(0, 255));
      rack  = 1'($urandom_range(0, 1));
      rhalf = $urandom_range(30, 70);
      start_frame(rd);
      device_clock(rhalf, rack, 11);
      finish_frame(rd, rack, !rack, model_parity(rd));
    end

    // send while busy in DATA must not disturb the frame
    start_frame(8'hA5);
    fork
      device_clock(40, 1'b1, 11);
      begin
        for (int i = 0; i < 3000 && dev_rises < 3; i++) @(negedge clk);
        bus.din  = 8'h5A;
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        bus.din  = 8'h00;
      end
    join
    finish_frame(8'hA5, 1'b1, 1'b0, model_parity(8'hA5));

    // reset while bit 4 is on the line
    start_frame(8'h3C);
    fork
      device_clock(40, 1'b1, 11);
      begin
        for (int i = 0; i < 3000 && dev_rises < 4; i++) @(negedge clk);
        wait_cycles(50);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_oe", int'({ps2clk_oe, ps2data_oe}), 0);
        chk("midreset_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
      end
    join
    chk("midreset_no_done", done_pulses - done_base, 0);
    wait_cycles(20);
    start_frame(CMD_RESET);
    device_clock(40, 1'b1, 11);
    finish_frame(CMD_RESET, 1'b1, 1'b0, 1'b1);

    // device stops clocking after bit 2
    start_frame(8'h96);
    device_clock(40, 1'b1, 3);
`ifdef PS2TX_TIMEOUT_EN
    begin
      int elapsed;
      wait_done(TB_TIMEOUT + 500, seen);
      elapsed = cyc - last_fall_cyc;
      chk("timeout_done_seen", int'(seen), 1);
      chk("timeout_latency", (elapsed >= TB_TIMEOUT - 3 && elapsed <= TB_TIMEOUT + 3) ? TB_TIMEOUT : elapsed, TB_TIMEOUT);
      chk("timeout_error", int'(bus.error), 1);
      chk("timeout_ack_ok", int'(bus.ack_ok), 0);
      wait_cycles(2);
      chk("timeout_oe", int'({ps2clk_oe, ps2data_oe}), 0);
      $display("stall din=96 elapsed=%0d error=%0d", elapsed, bus.error);
    end
`else
    begin
      int drops = 0;
      for (int i = 0; i < 8000; i++) begin
        @(negedge clk);
        if (!bus.busy) drops++;
      end
      chk("stall_busy_drops", drops, 0);
      chk("stall_no_done", done_pulses - done_base, 0);
      $display("stall din=96 busy_drops=%0d", drops);
      rst_n = 1'b0;
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(2);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
